// File: rtl/ysyx_040066_ifu_if.sv
`timescale 1ns/1ps
// ysyx_040066_ifu_if -- IFU boundary bundle.
//   EX redirect : ex_is_jmp, ex_nxtpc
//   imem request: imem_req_valid/ready/addr  (valid/ready)
//   imem resp   : imem_resp_valid/data       (valid only, one per accepted request)
//   ID handoff  : if_valid/id_ready, if_pc, if_inst, if_misalign
// master = IFU side, slave = environment (EX, memory, ID).
interface ysyx_040066_ifu_if;
  logic        ex_is_jmp;
  logic [63:0] ex_nxtpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        id_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  modport master (
    input  ex_is_jmp, ex_nxtpc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_misalign
  );

  modport slave (
    output ex_is_jmp, ex_nxtpc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_misalign
  );
endinterface

// File: rtl/ysyx_040066_ifu.sv
`timescale 1ns/1ps
// ysyx_040066_ifu -- instruction fetch unit.
// Owns the architectural PC, issues one imem request at a time, holds the fetched
// {pc,inst} for ID and squashes wrong-path fetches on an EX redirect.
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   bus       ysyx_040066_ifu_if.master (redirect, imem req/resp, ID handoff)
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with [1:0]!=0 skips the fetch and presents a
//               nop with if_misalign=1 so ID can trap; pc does not advance on handoff.
//   undefined : no check, if_misalign tied low, target fetched as-is.
module ysyx_040066_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic               clk,
  input logic               rst,
  ysyx_040066_ifu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        drop;      // a response for a squashed request is still in flight
  logic [63:0] if_pc_q;
  logic [31:0] if_inst_q;

  logic jmp, rsp, acc, stale_out;
  assign jmp       = bus.ex_is_jmp;
  assign rsp       = bus.imem_resp_valid;
  assign acc       = (state == REQ) && bus.imem_req_ready;
  // leaving HOLD with a stale response still pending must absorb it before re-requesting
  assign stale_out = drop && !rsp;

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  // redirect kills the handoff in the same cycle
  assign bus.if_valid       = (state == HOLD) && !jmp;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_inst        = if_inst_q;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q;
  logic mis_tgt;
  assign mis_tgt         = jmp && (bus.ex_nxtpc[1:0] != 2'b00);
  assign bus.if_misalign = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 mis_q <= 1'b0;
    else if (jmp)                            mis_q <= mis_tgt;
    else if (state == HOLD && bus.id_ready)  mis_q <= 1'b0;
  end
`else
  assign bus.if_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      if_pc_q   <= RESET_PC;
      if_inst_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (jmp) pc <= bus.ex_nxtpc;
        end
        REQ: begin
          if (jmp) begin
            pc <= bus.ex_nxtpc;
            // old address got accepted anyway: its response is stale
            if (acc) begin
              drop  <= 1'b1;
              state <= WAIT;
            end
          end else if (acc) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (jmp) begin
            pc   <= bus.ex_nxtpc;
            drop <= !rsp;
            if (rsp) state <= REQ;
          end else if (rsp) begin
            drop <= 1'b0;
            if (drop) begin
              state <= REQ;
            end else begin
              if_pc_q   <= pc;
              if_inst_q <= bus.imem_resp_data;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (jmp) begin
            pc    <= bus.ex_nxtpc;
            state <= stale_out ? WAIT : REQ;
          end else if (bus.id_ready) begin
            pc    <= pc + 64'd4;
            state <= stale_out ? WAIT : REQ;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef IFU_MISALIGN_CHECK_EN
      // only the misaligned-redirect path can leave a stale response outside WAIT
      if (rsp && drop && state != WAIT) drop <= 1'b0;
      if (mis_tgt) begin
        state     <= HOLD;
        if_pc_q   <= bus.ex_nxtpc;
        if_inst_q <= 32'h0000_0013;
      end
      if (state == HOLD && !jmp && bus.id_ready && mis_q) pc <= pc;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_040066_ifu.sv
`timescale 1ns/1ps
module tb_ysyx_040066_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam int EV_ACC = 0, EV_HS = 1, EV_JMP = 2;

  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  logic clk, rst;
  ysyx_040066_ifu_if bus();
  ysyx_040066_ifu #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int cyc = 0, hs_cnt = 0, outstanding = 0, proto_err = 0;
  int cd = 0, rdy_pct = 100, mem_delay = 1;
  bit rnd_delay = 0;
  logic [63:0] pend;
  ev_t evq[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // n-th event of a kind (stale accepts skipped); x when absent
  function automatic logic [63:0] ev_a(input int kind, input int n);
    int c = 0;
    foreach (evq[i])
      if (evq[i].kind == kind && !(kind == EV_ACC && evq[i].d[0])) begin
        if (c == n) return evq[i].a;
        c++;
      end
    return {64{1'bx}};
  endfunction

  function automatic int ev_cyc(input int kind, input int n);
    int c = 0;
    foreach (evq[i])
      if (evq[i].kind == kind && !(kind == EV_ACC && evq[i].d[0])) begin
        if (c == n) return evq[i].cyc;
        c++;
      end
    return -1000;
  endfunction

  // One clock: log handshakes seen before the edge, then play memory for the next cycle.
  task automatic cycle();
    logic acc, hs, jmp, rsp, ifv;
    logic [63:0] aaddr, pcs, tgt;
    logic [31:0] inst;
    #1;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    aaddr = bus.imem_req_addr;
    hs = bus.if_valid && bus.id_ready;
    pcs = bus.if_pc; inst = bus.if_inst;
    jmp = bus.ex_is_jmp; tgt = bus.ex_nxtpc; ifv = bus.if_valid;
    rsp = bus.imem_resp_valid;
    if (acc) begin
      if (outstanding != 0) proto_err++;
      evq.push_back('{EV_ACC, aaddr, {31'b0, jmp}, cyc});
    end
    if (hs) begin
      evq.push_back('{EV_HS, pcs, inst, cyc});
      hs_cnt++;
    end
    if (jmp) evq.push_back('{EV_JMP, tgt, {31'b0, ifv}, cyc});
    @(posedge clk); #1;
    cyc++;
    if (rsp) outstanding--;
    if (acc) begin
      outstanding++;
      pend = aaddr;
      cd = rnd_delay ? int'($urandom_range(4, 1)) : mem_delay;
    end
    bus.imem_resp_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(pend);
      end
    end
    bus.imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
  endtask

  task automatic run_hs(input int n, input int max);
    for (int k = 0; k < max && hs_cnt < n; k++) cycle();
  endtask

  // leaves the DUT in IDLE, posedge+1, rst low
  task automatic do_reset();
    rst = 1'b1;
    bus.ex_is_jmp = 1'b0; bus.ex_nxtpc = '0; bus.id_ready = 1'b1;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.imem_req_ready = (rdy_pct != 0);
    cd = 0; outstanding = 0; hs_cnt = 0; evq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    rst = 1'b1; #1;
    bus.ex_is_jmp = 1'b0; bus.id_ready = 1'b1;
    do_reset();
    rst = 1'b1; #2;
    vecs++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    vecs++; if (bus.imem_req_addr !== RST_PC) begin errs++; $display("FAIL rst_addr: got %h want %h", bus.imem_req_addr, RST_PC); end
    vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL rst_if_valid: got %b want 0", bus.if_valid); end
    vecs++; if (bus.if_pc !== RST_PC) begin errs++; $display("FAIL rst_if_pc: got %h want %h", bus.if_pc, RST_PC); end
    vecs++; if (bus.if_inst !== 32'h0) begin errs++; $display("FAIL rst_if_inst: got %h want 0", bus.if_inst); end
    vecs++; if (bus.if_misalign !== 1'b0) begin errs++; $display("FAIL rst_misalign: got %b want 0", bus.if_misalign); end
    do_reset();
    vecs++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL idle_req_valid: got %b want 0", bus.imem_req_valid); end
    cycle();
    vecs++; if (bus.imem_req_valid !== 1'b1) begin errs++; $display("FAIL req_after_idle: got %b want 1", bus.imem_req_valid); end
  endtask

  task automatic test_zero_wait();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    do_reset();
    run_hs(3, 40);
    vecs++; if (hs_cnt < 3) begin errs++; $display("FAIL zw_progress: got %0d handoffs want 3", hs_cnt); end
    for (int i = 0; i < 3; i++) begin
      vecs++; if (ev_a(EV_ACC, i) !== RST_PC + 64'(4 * i)) begin errs++; $display("FAIL zw_addr%0d: got %h want %h", i, ev_a(EV_ACC, i), RST_PC + 64'(4 * i)); end
      vecs++; if (ev_a(EV_HS, i) !== RST_PC + 64'(4 * i)) begin errs++; $display("FAIL zw_pc%0d: got %h want %h", i, ev_a(EV_HS, i), RST_PC + 64'(4 * i)); end
    end
    for (int i = 1; i < 3; i++) begin
      vecs++; if (ev_cyc(EV_HS, i) - ev_cyc(EV_HS, i - 1) !== 3) begin errs++; $display("FAIL zw_spacing%0d: got %0d want 3", i, ev_cyc(EV_HS, i) - ev_cyc(EV_HS, i - 1)); end
    end
  endtask

  task automatic test_ready_stall();
    rdy_pct = 0; mem_delay = 1; rnd_delay = 0;
    do_reset();
    cycle();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC || bus.if_valid !== 1'b0) begin
        errs++; $display("FAIL stall%0d: got v=%b a=%h ifv=%b want v=1 a=%h ifv=0", i, bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, RST_PC);
      end
      cycle();
    end
    rdy_pct = 100; bus.imem_req_ready = 1'b1;
    run_hs(1, 20);
    vecs++; if (ev_a(EV_HS, 0) !== RST_PC) begin errs++; $display("FAIL stall_pc: got %h want %h", ev_a(EV_HS, 0), RST_PC); end
    vecs++; if (evq[0].cyc < 5) begin errs++; $display("FAIL stall_accept_cycle: got %0d want >=5", evq[0].cyc); end
  endtask

  task automatic test_redirect_wait();
    rdy_pct = 100; mem_delay = 3; rnd_delay = 0;
    do_reset();
    cycle(); cycle();
    bus.ex_is_jmp = 1'b1; bus.ex_nxtpc = 64'h8000_0100;
    cycle();
    bus.ex_is_jmp = 1'b0;
    vecs++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL rw_wait_hold: got req_valid %b want 0", bus.imem_req_valid); end
    run_hs(1, 30);
    vecs++; if (ev_a(EV_ACC, 1) !== 64'h8000_0100) begin errs++; $display("FAIL rw_req_addr: got %h want 80000100", ev_a(EV_ACC, 1)); end
    vecs++; if (ev_a(EV_HS, 0) !== 64'h8000_0100) begin errs++; $display("FAIL rw_hs_pc: got %h want 80000100", ev_a(EV_HS, 0)); end
    vecs++; if (evq.size() > 0 && evq[evq.size()-1].d !== mem_word(64'h8000_0100)) begin errs++; $display("FAIL rw_hs_inst: got %h want %h", evq[evq.size()-1].d, mem_word(64'h8000_0100)); end
    vecs++; if (proto_err !== 0) begin errs++; $display("FAIL rw_one_outstanding: got %0d overlaps want 0", proto_err); end
  endtask

  task automatic test_redirect_hold();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    do_reset();
    bus.id_ready = 1'b0;
    for (int k = 0; k < 20 && bus.if_valid !== 1'b1; k++) cycle();
    vecs++; if (bus.if_valid !== 1'b1 || bus.if_pc !== RST_PC) begin errs++; $display("FAIL rh_hold: got ifv=%b pc=%h want 1 %h", bus.if_valid, bus.if_pc, RST_PC); end
    bus.id_ready = 1'b1; bus.ex_is_jmp = 1'b1; bus.ex_nxtpc = 64'h8000_0200;
    #1;
    vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL rh_gate: got if_valid %b want 0", bus.if_valid); end
    cycle();
    bus.ex_is_jmp = 1'b0;
    vecs++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0200) begin errs++; $display("FAIL rh_req: got v=%b a=%h want 1 80000200", bus.imem_req_valid, bus.imem_req_addr); end
    run_hs(1, 20);
    vecs++; if (ev_a(EV_HS, 0) !== 64'h8000_0200) begin errs++; $display("FAIL rh_hs_pc: got %h want 80000200", ev_a(EV_HS, 0)); end
  endtask

  task automatic test_wrap();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    do_reset();
    bus.ex_is_jmp = 1'b1; bus.ex_nxtpc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    bus.ex_is_jmp = 1'b0;
    run_hs(2, 30);
    vecs++; if (ev_a(EV_HS, 0) !== 64'hFFFF_FFFF_FFFF_FFFC) begin errs++; $display("FAIL wrap_pc0: got %h want fffffffffffffffc", ev_a(EV_HS, 0)); end
    vecs++; if (ev_a(EV_ACC, 1) !== 64'h0) begin errs++; $display("FAIL wrap_addr: got %h want 0", ev_a(EV_ACC, 1)); end
    vecs++; if (ev_a(EV_HS, 1) !== 64'h0) begin errs++; $display("FAIL wrap_pc1: got %h want 0", ev_a(EV_HS, 1)); end
  endtask

  task automatic test_misalign();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    do_reset();
    bus.ex_is_jmp = 1'b1; bus.ex_nxtpc = 64'h8000_0102;
    cycle();
    bus.ex_is_jmp = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    bus.id_ready = 1'b0;
    cycle();
    vecs++; if (bus.imem_req_valid !== 1'b0 || evq.size() != 1) begin errs++; $display("FAIL mis_noreq: got v=%b events=%0d want 0 1", bus.imem_req_valid, evq.size()); end
    vecs++; if (bus.if_valid !== 1'b1 || bus.if_misalign !== 1'b1) begin errs++; $display("FAIL mis_flags: got ifv=%b mis=%b want 1 1", bus.if_valid, bus.if_misalign); end
    vecs++; if (bus.if_pc !== 64'h8000_0102 || bus.if_inst !== 32'h0000_0013) begin errs++; $display("FAIL mis_data: got %h %h want 80000102 00000013", bus.if_pc, bus.if_inst); end
`else
    vecs++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0102) begin errs++; $display("FAIL mis_asis_req: got v=%b a=%h want 1 80000102", bus.imem_req_valid, bus.imem_req_addr); end
    run_hs(1, 20);
    vecs++; if (ev_a(EV_HS, 0) !== 64'h8000_0102 || bus.if_misalign !== 1'b0) begin errs++; $display("FAIL mis_asis_hs: got %h mis=%b want 80000102 0", ev_a(EV_HS, 0), bus.if_misalign); end
`endif
  endtask

  task automatic test_async_reset();
    rdy_pct = 100; mem_delay = 1; rnd_delay = 0;
    do_reset();
    bus.ex_is_jmp = 1'b1; bus.ex_nxtpc = 64'h8000_0300;
    cycle();
    bus.ex_is_jmp = 1'b0;
    run_hs(1, 20);
    mem_delay = 5;
    cycle();
    #3 rst = 1'b1;
    #1;
    vecs++; if (bus.imem_req_addr !== RST_PC || bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL arst_req: got v=%b a=%h want 0 %h", bus.imem_req_valid, bus.imem_req_addr, RST_PC); end
    vecs++; if (bus.if_pc !== RST_PC || bus.if_inst !== 32'h0 || bus.if_valid !== 1'b0) begin errs++; $display("FAIL arst_if: got pc=%h inst=%h v=%b want %h 0 0", bus.if_pc, bus.if_inst, bus.if_valid, RST_PC); end
    mem_delay = 1;
    do_reset();
    run_hs(1, 20);
    vecs++; if (ev_a(EV_HS, 0) !== RST_PC) begin errs++; $display("FAIL arst_refetch: got %h want %h", ev_a(EV_HS, 0), RST_PC); end
  endtask

  // Architectural reference: the ID stream is consecutive PCs, restarted at every redirect
  // target, each carrying the memory word at its PC; every live request is for that next PC.
  task automatic test_random();
    logic [63:0] exp;
    logic [63:0] tgt;
    rdy_pct = 70; rnd_delay = 1; proto_err = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.id_ready = ($urandom_range(99, 0) < 75);
      bus.ex_is_jmp = ($urandom_range(99, 0) < 4);
      tgt = 64'h8000_0000 + 64'($urandom_range(255, 0) * 4);
      if ($urandom_range(7, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3, 0) * 4);
      bus.ex_nxtpc = tgt;
      cycle();
    end
    bus.ex_is_jmp = 1'b0;
    exp = RST_PC;
    foreach (evq[i]) begin
      case (evq[i].kind)
        EV_ACC: if (!evq[i].d[0]) begin
          vecs++; if (evq[i].a !== exp) begin errs++; $display("FAIL rnd_req@%0d: got %h want %h", evq[i].cyc, evq[i].a, exp); end
        end
        EV_HS: begin
          vecs++; if (evq[i].a !== exp || evq[i].d !== mem_word(exp)) begin errs++; $display("FAIL rnd_hs@%0d: got %h/%h want %h/%h", evq[i].cyc, evq[i].a, evq[i].d, exp, mem_word(exp)); end
          exp = exp + 64'd4;
        end
        default: begin
          vecs++; if (evq[i].d[0] !== 1'b0) begin errs++; $display("FAIL rnd_gate@%0d: got if_valid 1 want 0", evq[i].cyc); end
          exp = evq[i].a;
        end
      endcase
    end
    vecs++; if (hs_cnt < 100) begin errs++; $display("FAIL rnd_progress: got %0d handoffs want >=100", hs_cnt); end
    vecs++; if (proto_err !== 0) begin errs++; $display("FAIL rnd_one_outstanding: got %0d overlaps want 0", proto_err); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_zero_wait();
    test_ready_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
